// File: rtl/hsi_vector_streamer_if.sv
// hsi_vector_streamer_if
//   Memory read port plus the two FIFO push streams of the HSI vector streamer.
//   master : streamer side (issues reads, pushes words)
//   slave  : memory / MSE engine side (returns read data, reports FIFO full)
//   Signals:
//     mem_rd_en, mem_addr   read strobe and word address
//     mem_rdata             read data, one cycle after mem_rd_en
//     sample_out_en/_out    sample FIFO push + word, sample_out_full back-pressure
//     ref_out_en/_out       reference FIFO push + word, ref_out_full back-pressure
interface hsi_vector_streamer_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 16
);
  logic                      mem_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0]     mem_rdata;
  logic                      sample_out_en;
  logic [WORD_WIDTH-1:0]     sample_out;
  logic                      sample_out_full;
  logic                      ref_out_en;
  logic [WORD_WIDTH-1:0]     ref_out;
  logic                      ref_out_full;

  modport master (
    output mem_rd_en, mem_addr, input mem_rdata,
    output sample_out_en, sample_out, input sample_out_full,
    output ref_out_en, ref_out, input ref_out_full
  );

  modport slave (
    input mem_rd_en, mem_addr, output mem_rdata,
    input sample_out_en, sample_out, output sample_out_full,
    input ref_out_en, ref_out, output ref_out_full
  );
endinterface

// File: rtl/hsi_vector_streamer.sv
// hsi_vector_streamer
//   Producer for the MSE engine FIFO word interface. On start it reads one
//   sample vector (WORDS_PER_VECTOR words at sample_base_in) followed by N
//   contiguous library vectors (starting at library_base_in) from a memory
//   with one-cycle read latency, and pushes them to the sample / reference
//   FIFOs in read order through a 2-entry tagged skid buffer.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start               begin transfer (accepted only while ready)
//     library_length_in   reference vector count, 0 means HSI_LIBRARY_SIZE
//     sample_base_in      word address of the sample vector
//     library_base_in     word address of library vector 0
//     bus (master)        memory read port + sample/ref push streams
//     done                one-cycle pulse at end of transfer
//     idle, ready         high while in IDLE
//   Optional feature (macro HSI_STREAM_STALL_CNT_EN):
//     stall_cycles_out    saturating count of cycles the buffer head was
//                         blocked by its destination full flag
module hsi_vector_streamer #(
  parameter int WORD_WIDTH            = 32,
  parameter int DATA_WIDTH            = 16,
  parameter int HSI_BANDS             = 128,
  parameter int HSI_LIBRARY_SIZE      = 256,
  parameter int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
  parameter int MEM_ADDR_WIDTH        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_length_in,
  input  logic [MEM_ADDR_WIDTH-1:0]        sample_base_in,
  input  logic [MEM_ADDR_WIDTH-1:0]        library_base_in,
  hsi_vector_streamer_if.master            bus,
  output logic                             done,
  output logic                             idle,
`ifdef HSI_STREAM_STALL_CNT_EN
  output logic                             ready,
  output logic [31:0]                      stall_cycles_out
`else
  output logic                             ready
`endif
);
  localparam int WORDS_PER_VECTOR = HSI_BANDS * DATA_WIDTH / WORD_WIDTH;
  localparam int KW = (WORDS_PER_VECTOR > 1) ? $clog2(WORDS_PER_VECTOR) : 1;
  localparam int LW = HSI_LIBRARY_SIZE_ADDR + 1;
  localparam logic [KW-1:0] K_LAST  = KW'(WORDS_PER_VECTOR - 1);
  localparam logic [LW-1:0] LIB_MAX = LW'(HSI_LIBRARY_SIZE);

  typedef enum logic [2:0] {IDLE, SAMPLE, LIBRARY, DRAIN, DONE} state_t;

  state_t                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q, lib_base_q;
  logic [LW-1:0]             len_q, vec_q;
  logic [KW-1:0]             k_q;
  logic                      done_q, idle_q, ready_q;

  // 2-entry buffer of {word, dest}; dest 1 = sample, 0 = reference
  logic [WORD_WIDTH-1:0] buf_word_q [2];
  logic                  buf_dst_q  [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  inflight_q, inflight_tag_q;

  logic       head_vld, head_smp, head_full, pop, issue;
  logic [2:0] occ_after;

  assign head_vld  = (count_q != 2'd0);
  assign head_smp  = buf_dst_q[rd_ptr_q];
  assign head_full = head_smp ? bus.sample_out_full : bus.ref_out_full;
  assign pop       = head_vld && !head_full;

  // Counting this cycle's pop lets a read issue into the slot being freed,
  // which sustains one word per cycle with a single-cycle memory.
  assign occ_after = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};
  assign issue     = ((state_q == SAMPLE) || (state_q == LIBRARY)) && (occ_after < 3'd2);

  assign bus.mem_rd_en     = issue;
  assign bus.mem_addr      = rd_addr_q;
  assign bus.sample_out_en = head_vld &&  head_smp && !bus.sample_out_full;
  assign bus.ref_out_en    = head_vld && !head_smp && !bus.ref_out_full;
  assign bus.sample_out    = buf_word_q[rd_ptr_q];
  assign bus.ref_out       = buf_word_q[rd_ptr_q];

  assign done  = done_q;
  assign idle  = idle_q;
  assign ready = ready_q;

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      lib_base_q <= '0;
      len_q      <= '0;
      vec_q      <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          rd_addr_q  <= sample_base_in;
          lib_base_q <= library_base_in;
          len_q      <= (library_length_in == '0) ? LIB_MAX : LW'(library_length_in);
          vec_q      <= '0;
          k_q        <= '0;
          idle_q     <= 1'b0;
          ready_q    <= 1'b0;
          state_q    <= SAMPLE;
        end
        SAMPLE: if (issue) begin
          if (k_q == K_LAST) begin
            k_q       <= '0;
            rd_addr_q <= lib_base_q;
            state_q   <= LIBRARY;
          end else begin
            k_q       <= k_q + 1'b1;
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        LIBRARY: if (issue) begin
          // library vectors are contiguous, so the address simply increments
          rd_addr_q <= rd_addr_q + 1'b1;
          if (k_q == K_LAST) begin
            k_q   <= '0;
            vec_q <= vec_q + 1'b1;
            if (vec_q == len_q - LW'(1)) state_q <= DRAIN;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DRAIN: if (count_q == 2'd0 && !inflight_q) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          idle_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-return capture and buffer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_tag_q <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      buf_word_q[0]  <= '0;
      buf_word_q[1]  <= '0;
      buf_dst_q[0]   <= 1'b0;
      buf_dst_q[1]   <= 1'b0;
    end else begin
      inflight_q     <= issue;
      inflight_tag_q <= (state_q == SAMPLE);
      if (inflight_q) begin
        buf_word_q[wr_ptr_q] <= bus.mem_rdata;
        buf_dst_q[wr_ptr_q]  <= inflight_tag_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

`ifdef HSI_STREAM_STALL_CNT_EN
  logic [31:0] stall_q;
  assign stall_cycles_out = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if (head_vld && head_full && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hsi_vector_streamer.sv
// Directed bench for hsi_vector_streamer. Memory word at address a reads as
// {a ^ 16'h5A5A, a}; a negedge monitor checks every push against that image.
module tb_hsi_vector_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  library_length_in = '0;
  logic [15:0] sample_base_in = '0;
  logic [15:0] library_base_in = '0;
  logic        done, idle, ready;
`ifdef HSI_STREAM_STALL_CNT_EN
  logic [31:0] stall_cycles_out;
`endif

  hsi_vector_streamer_if #(.WORD_WIDTH(32), .MEM_ADDR_WIDTH(16)) bus();

  hsi_vector_streamer dut (
    .clk(clk), .rst(rst), .start(start),
    .library_length_in(library_length_in),
    .sample_base_in(sample_base_in),
    .library_base_in(library_base_in),
    .bus(bus.master),
    .done(done), .idle(idle),
`ifdef HSI_STREAM_STALL_CNT_EN
    .ready(ready), .stall_cycles_out(stall_cycles_out)
`else
    .ready(ready)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mw(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mw(bus.mem_addr) : 32'hDEAD_BEEF;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor state
  logic [15:0] exp_sb = '0, exp_lb = '0;
  int s_cnt, r_cnt, data_err, order_err, both_err, full_err, done_cnt;
  int first_cyc, last_cyc, done_cyc;
  logic [31:0] first_s_word, last_r_word;

  task automatic mon_clear();
    s_cnt = 0; r_cnt = 0; data_err = 0; order_err = 0; both_err = 0;
    full_err = 0; done_cnt = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0;
    first_s_word = '0; last_r_word = '0;
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.sample_out_en && bus.ref_out_en) both_err++;
    if (bus.sample_out_en) begin
      if (bus.sample_out_full) full_err++;
      if (r_cnt != 0) order_err++;
      if (bus.sample_out !== mw(exp_sb + 16'(s_cnt))) data_err++;
      if (s_cnt == 0) begin first_cyc = cyc; first_s_word = bus.sample_out; end
      last_cyc = cyc;
      s_cnt++;
    end
    if (bus.ref_out_en) begin
      if (bus.ref_out_full) full_err++;
      if (s_cnt != 64) order_err++;
      if (bus.ref_out !== mw(exp_lb + 16'(r_cnt))) data_err++;
      last_r_word = bus.ref_out;
      last_cyc = cyc;
      r_cnt++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int start_cyc, bp_r_release;

  // One transfer. bp_at >= 0 holds ref_out_full for 20 cycles once that many
  // ref words have gone out; tog toggles sample_out_full during the sample
  // phase; pulse_at >= 0 re-pulses start once that many ref words are out.
  task automatic run(input string tag, input int len, input logic [15:0] sb,
                     input logic [15:0] lb, input int bp_at, input bit tog,
                     input int pulse_at);
    int bp_state, bp_n, exp_r;
    bit pulsed;
    bp_state = 0; bp_n = 0; pulsed = 0; bp_r_release = -1;
    exp_r = (len == 0) ? 256 * 64 : len * 64;
    exp_sb = sb; exp_lb = lb;
    mon_clear();
    library_length_in = 8'(len); sample_base_in = sb; library_base_in = lb;
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20000 && done_cnt == 0; n++) begin
      if (bp_at >= 0 && bp_state == 0 && r_cnt == bp_at) bp_state = 1;
      if (bp_state == 1) begin
        if (bp_n < 20) begin bus.ref_out_full = 1'b1; bp_n++; end
        else begin bus.ref_out_full = 1'b0; bp_state = 2; bp_r_release = r_cnt; end
      end
      if (tog && s_cnt < 64) bus.sample_out_full = ~bus.sample_out_full;
      else bus.sample_out_full = 1'b0;
      start = (pulse_at >= 0 && !pulsed && r_cnt >= pulse_at);
      if (start) pulsed = 1;
      tick();
    end
    start = 1'b0; bus.sample_out_full = 1'b0; bus.ref_out_full = 1'b0;
    repeat (4) tick();
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_s_cnt"}, s_cnt, 64);
    chk({tag, "_r_cnt"}, r_cnt, exp_r);
    chk({tag, "_data_err"}, data_err, 0);
    chk({tag, "_order_err"}, order_err, 0);
    chk({tag, "_both_err"}, both_err, 0);
    chk({tag, "_full_err"}, full_err, 0);
    chk({tag, "_idle_after"}, {idle, ready}, 2'b11);
  endtask

  int cyc_a, cyc_b, pushes;

  initial begin
    bus.sample_out_full = 1'b0;
    bus.ref_out_full = 1'b0;
    mon_clear();
    repeat (3) tick();
    chk("rst_idle", idle, 1);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_push", {bus.sample_out_en, bus.ref_out_en}, 2'b00);
    chk("rst_words", {bus.sample_out, bus.ref_out}, 64'h0);
    rst = 1'b0;
    tick();

    // basic 3-vector transfer, no back-pressure
    run("len3", 3, 16'h0100, 16'h1000, -1, 0, -1);
    chk("len3_first_word", first_s_word, mw(16'h0100));
    chk("len3_last_word", last_r_word, mw(16'h10BF));
    chk("len3_back_to_back", last_cyc - first_cyc, 255);
    chk("len3_latency_ge2", (first_cyc - start_cyc) >= 2, 1);
    chk("len3_done_after", done_cyc > last_cyc, 1);

    // length 0 means the full 256-vector library
    run("len0", 0, 16'h0100, 16'h1000, -1, 0, -1);
    chk("len0_last_word", last_r_word, mw(16'h4FFF));

    // address wrap through 0xFFFF
    run("wrap", 1, 16'hFFF0, 16'hFFE0, -1, 0, -1);
    chk("wrap_first_word", first_s_word, mw(16'hFFF0));
    chk("wrap_last_word", last_r_word, mw(16'h001F));

    // ref back-pressure for 20 cycles at ref word 10
    run("bp", 1, 16'h0200, 16'h3000, 10, 0, -1);
    chk("bp_held_at_10", bp_r_release, 10);
`ifdef HSI_STREAM_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cycles_out, 20);
`endif

    // sample full toggling during the sample phase
    run("tog", 1, 16'h0400, 16'h0500, -1, 1, -1);

    // reset in the middle of a length-2 transfer
    exp_sb = 16'h0600; exp_lb = 16'h0700;
    mon_clear();
    library_length_in = 8'd2; sample_base_in = 16'h0600; library_base_in = 16'h0700;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_idle", {idle, ready}, 2'b11);
    chk("mid_rst_no_push", {bus.sample_out_en, bus.ref_out_en}, 2'b00);
    pushes = s_cnt + r_cnt;
    tick();
    chk("mid_rst_quiet", s_cnt + r_cnt, pushes);
    run("after_rst", 2, 16'h0600, 16'h0700, -1, 0, -1);

    // start re-pulsed during LIBRARY must not disturb the transfer
    run("ref_run", 2, 16'h0800, 16'h0900, -1, 0, -1);
    cyc_a = done_cyc - start_cyc;
    run("repulse", 2, 16'h0800, 16'h0900, -1, 0, 5);
    cyc_b = done_cyc - start_cyc;
    chk("repulse_timing", cyc_b, cyc_a);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
